// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller and the ALU: FSM states,
// opcode/funct fields, the internal aluop code and the ALU control codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // Opcode field [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Function field [5:0] for R-type
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Controller-to-aludec operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes understood by the ALU
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-input and PC source selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/controller_fsm_if.sv
// Controller <-> datapath bundle. master = the controller (drives the
// datapath controls, reads instruction fields and the ALU zero flag);
// slave = the datapath.
interface controller_fsm_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol
    );
endinterface

// File: rtl/controller_fsm_aludec.sv
// ALU decoder: maps the controller's aluop class and the R-type funct field
// to the ALU control code. Purely combinational.
module aludec
    import ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Unknown aluop classes and unknown functs both fall back to ADD.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/controller_fsm.sv
// Multicycle MIPS-style controller: Moore FSM whose datapath controls are
// decoded from the current state. While reset is high the outputs show FETCH
// values with every write enable held low, so nothing is committed.
module controller_fsm
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    controller_fsm_if.master  bus
);

    state_t     state_reg;
    state_t     state_next;
    state_t     out_state;

    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic [2:0] alucontrol_dec;

    // State register; reset returns to FETCH from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; undefined opcodes fall straight back to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Moore output decode; during reset the FETCH row is shown.
    always_comb begin
        out_state    = reset ? S_FETCH : state_reg;
        bus.iord     = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        regwrite_raw = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = SRCB_REG;
        bus.pcsrc    = PCSRC_ALU;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = ALUOP_ADD;
        case (out_state)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = SRCB_FOUR;
            end
            S_DECODE:  bus.alusrcb = SRCB_IMMSH2;
            S_MEMADR, S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
            end
            S_MEMRD:   bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                bus.regdst   = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = PCSRC_ALUOUT;
                branch      = 1'b1;
            end
            S_ADDIWB:  regwrite_raw = 1'b1;
            S_JEX: begin
                bus.pcsrc = PCSRC_JUMP;
                pcwrite   = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are suppressed while reset is held.
    assign bus.irwrite  = irwrite_raw  & ~reset;
    assign bus.regwrite = regwrite_raw & ~reset;
    assign bus.memwrite = memwrite_raw & ~reset;
    assign bus.pcen     = (pcwrite | (branch & bus.zero)) & ~reset;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (alucontrol_dec)
    );

    assign bus.alucontrol = alucontrol_dec;

endmodule

// File: doc/controller_fsm.md
CONTROLLER_FSM -- requirements
Module: controller_fsm

Interface
REQ-001 Parameters: none; all encodings SHALL come from package ctrl_pkg.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field [31:26].
REQ-005 funct  input  6  instruction function field [5:0].
REQ-006 zero  input  1  ALU zero flag, same-cycle combinational from the ALU.
REQ-007 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  output  1 each  datapath controls.
REQ-008 alusrcb  output  2  ALU B select: 00 reg, 01 const 4, 10 signext imm, 11 imm<<2.
REQ-009 pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 pcen  output  1  PC write enable = pcwrite | (branch & zero).
REQ-011 alucontrol  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.

Function
REQ-012 Multicycle Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-013 FETCH->DECODE always; DECODE dispatches on op: 100011/101011 -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 001000 -> ADDIEX, 000010 -> JEX, any other -> FETCH (treated as NOP).
REQ-014 MEMADR -> MEMRD if op=100011, else MEMWR; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
REQ-015 Per-state asserted outputs (all others 0): FETCH irwrite, pcwrite, alusrcb=01, aluop=00; DECODE alusrcb=11, aluop=00; MEMADR alusrca, alusrcb=10; MEMRD iord; MEMWB memtoreg, regwrite; MEMWR iord, memwrite; RTYPEEX alusrca, aluop=10; RTYPEWB regdst, regwrite; BEQEX alusrca, aluop=01, pcsrc=01, branch; ADDIEX alusrca, alusrcb=10; ADDIWB regwrite; JEX pcsrc=10, pcwrite.
REQ-016 Internal aluop decode: 00 -> 010, 01 -> 110, 10 -> by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, other -> 010.
REQ-017 Outputs SHALL be combinational from current state (plus funct for alucontrol, zero for pcen); zero latency from state to outputs.
REQ-018 Instruction latency: lw 5 cycles, sw/R-type/addi 4, beq/j 3, unknown op 2.
REQ-019 In BEQEX, pcen SHALL equal zero sampled that same cycle; branch not taken leaves pcen=0.

Reset
REQ-020 reset high on a rising edge SHALL load FETCH regardless of current state, including mid-instruction.
REQ-021 While reset is high, pcen, irwrite, regwrite and memwrite SHALL be forced 0; other outputs follow FETCH values.
REQ-022 First cycle after reset deasserts SHALL be a normal FETCH (pcen=1, irwrite=1).

Structure
REQ-023 ctrl_pkg SHALL hold the state enum, opcode constants, funct constants, aluop codes and alucontrol codes shared with the ALU.
REQ-024 ALU decode (REQ-016) SHALL be a separate combinational sub-module aludec; FSM and output logic stay in controller_fsm.

Verification
REQ-025 Reset then op=100011 held -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-026 op=000000, funct=101010 -> RTYPEEX alucontrol=111, next cycle regwrite=1, regdst=1; funct=111111 -> alucontrol=010.
REQ-027 op=000100 with zero=1 -> BEQEX pcen=1, alucontrol=110; repeat with zero=0 -> pcen=0; both return to FETCH.
REQ-028 op=000010 -> JEX pcsrc=10, pcen=1; op=111111 -> DECODE then FETCH, no write enable asserted.
REQ-029 Assert reset in MEMRD of a lw -> next state FETCH, regwrite never asserted, pcen=0 during reset cycle.
REQ-030 op=101011 -> MEMWR memwrite=1, iord=1, regwrite=0 throughout.
